// File: rtl/iomem_arbiter_pkg.sv
// iomem_arbiter_pkg: shared state encoding, master indices and grant helper for the iomem arbiter
package iomem_arbiter_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;
    localparam logic [31:0] DEF_TIMEOUT_RDATA = 32'hDEAD_BEEF;
    // Tie goes to the master that was not granted last; otherwise the sole requester.
    function automatic logic pick(input logic v0, input logic v1, input logic last);
        return (v0 && v1) ? ~last : ~v0;
    endfunction
endpackage

// File: rtl/iomem_arbiter_watchdog.sv
// iomem_arbiter_watchdog: per-transfer stall counter, done when TIMEOUT cycles have elapsed
//   clk/reset : clock, synchronous active-high reset
//   clr       : zero the counter (held while no transfer is granted)
//   en        : count this cycle (granted and no completion)
//   done      : counter has reached TIMEOUT-1; never asserted when TIMEOUT is 0
module iomem_arbiter_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic done
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk)
        if (reset || clr) cnt <= '0;
        else if (en && TIMEOUT != 0 && cnt != '1) cnt <= cnt + 1'b1;
    always_comb done = (TIMEOUT != 0) && (cnt == LAST);
endmodule

// File: rtl/iomem_arbiter.sv
// iomem_arbiter: round-robin sharing of the iomem bus between two masters with a stall watchdog
//   m0_*/m1_*      : master request (valid/addr/wdata/wstrb) and completion (ready/rdata)
//   s_*            : granted request toward the peripheral decoder, s_ready/s_rdata back
//   timeout_*      : sticky record of the first watchdog completion, cleared by timeout_clr
module iomem_arbiter import iomem_arbiter_pkg::*; #(
    parameter int          TIMEOUT       = 255,
    parameter logic [31:0] TIMEOUT_RDATA = DEF_TIMEOUT_RDATA,
    parameter int          CNT_W         = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        timeout_flag,
    output logic        timeout_master,
    output logic [31:0] timeout_addr,
    input  logic        timeout_clr
);
    state_t      state, state_n;
    logic        owner, owner_n, last_grant, last_n;
    logic        busy, own_valid, done, to_hit, fin, wd_done;
    logic [31:0] rdata;

    iomem_arbiter_watchdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wd (
        .clk(clk), .reset(reset), .clr(!busy), .en(s_valid && !s_ready), .done(wd_done)
    );

    always_comb begin
        busy      = state == ST_BUSY;
        own_valid = owner ? m1_valid : m0_valid;
        s_valid   = busy && own_valid;
        s_addr    = !busy ? '0 : owner ? m1_addr  : m0_addr;
        s_wdata   = !busy ? '0 : owner ? m1_wdata : m0_wdata;
        s_wstrb   = !busy ? '0 : owner ? m1_wstrb : m0_wstrb;
        done      = s_valid && s_ready;
        // A peripheral completion in the watchdog's final cycle takes precedence.
        to_hit    = s_valid && !s_ready && wd_done;
        fin       = done || to_hit;
        rdata     = done ? s_rdata : to_hit ? TIMEOUT_RDATA : '0;
        m0_ready  = fin && owner == M0;
        m1_ready  = fin && owner == M1;
        m0_rdata  = m0_ready ? rdata : '0;
        m1_rdata  = m1_ready ? rdata : '0;
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last_grant;
        if (!busy && (m0_valid || m1_valid)) begin
            state_n = ST_BUSY;
            owner_n = pick(m0_valid, m1_valid, last_grant);
        end else if (busy && (fin || !own_valid)) begin
            // Owner withdrawing its request aborts without affecting fairness.
            state_n = ST_IDLE;
            last_n  = fin ? owner : last_grant;
        end
    end

    always_ff @(posedge clk)
        if (reset) begin
            state      <= ST_IDLE;
            owner      <= M0;
            last_grant <= M1;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_grant <= last_n;
        end

    // Only the first fault is kept; a fault coinciding with a clear is recorded.
    always_ff @(posedge clk)
        if (reset) begin
            timeout_flag   <= 1'b0;
            timeout_master <= 1'b0;
            timeout_addr   <= '0;
        end else if (to_hit && (!timeout_flag || timeout_clr)) begin
            timeout_flag   <= 1'b1;
            timeout_master <= owner;
            timeout_addr   <= s_addr;
        end else if (timeout_clr) begin
            timeout_flag   <= 1'b0;
            timeout_master <= 1'b0;
            timeout_addr   <= '0;
        end
endmodule
